// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer driving an external 1-bit ALU slice
// alu_1bit is the matching slice; the sequencer only reaches it through the slice_* ports.

module alu_1bit (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [3:0] sel_i,
    output logic       f_o,
    output logic       cout_o
);
    logic aa;
    logic bb;

    always_comb begin
        aa     = a_i;
        bb     = 1'b0;
        f_o    = 1'b0;
        cout_o = 1'b0;
        if (sel_i[3:2] == 2'b00) begin
            // 00: A+cin, 01: A+B+cin, 10: A+~B+cin, 11: ~A+B+cin
            case (sel_i[1:0])
                2'b00:   bb = 1'b0;
                2'b01:   bb = b_i;
                2'b10:   bb = ~b_i;
                default: begin
                    aa = ~a_i;
                    bb = b_i;
                end
            endcase
            f_o    = aa ^ bb ^ cin_i;
            cout_o = (aa & bb) | (cin_i & (aa ^ bb));
        end else if (sel_i[3:2] == 2'b01) begin
            case (sel_i[1:0])
                2'b00:   f_o = a_i & b_i;
                2'b01:   f_o = a_i | b_i;
                2'b10:   f_o = a_i ^ b_i;
                default: f_o = ~(a_i | b_i);
            endcase
        end
    end
endmodule

module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_cin_o,
    output logic [3:0]       slice_sel_o,
    input  logic             slice_f_i,
    input  logic             slice_cout_i
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             run;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    // Shifts finish on the accept edge; only op_i[3:2] is looked at here.
                    if (op_i[3]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (op_i[2]) begin
                            result_d = {a_i[WIDTH-2:0], 1'b0};
                            cout_d   = a_i[WIDTH-1];
                        end else begin
                            result_d = {1'b0, a_i[WIDTH-1:1]};
                            cout_d   = a_i[0];
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d[idx_q] = slice_f_i;
                if (!op_q[2]) begin
                    carry_d = slice_cout_i;
                end
                if (idx_q == LAST_IDX) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = acc_d;
                    cout_d   = op_q[2] ? 1'b0 : slice_cout_i;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign run         = (state_q == RUN);
    assign slice_a_o   = run & a_q[idx_q];
    assign slice_b_o   = run & b_q[idx_q];
    assign slice_cin_o = run & carry_q;
    assign slice_sel_o = run ? op_q : 4'b0000;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign cout_o      = cout_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - self-checking bench for alu_serial_ctrl with alu_1bit as slice

module tb_alu_serial_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op_in = '0;
    logic          cin_in = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          busy, done, cout;
    logic [W-1:0]  result;
    logic          s_a, s_b, s_cin, s_f, s_cout;
    logic [3:0]    s_sel;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .op_i(op_in), .cin_i(cin_in),
        .a_i(a_in), .b_i(b_in), .busy_o(busy), .done_o(done), .result_o(result),
        .cout_o(cout), .slice_a_o(s_a), .slice_b_o(s_b), .slice_cin_o(s_cin),
        .slice_sel_o(s_sel), .slice_f_i(s_f), .slice_cout_i(s_cout)
    );

    alu_1bit slice (
        .a_i(s_a), .b_i(s_b), .cin_i(s_cin), .sel_i(s_sel), .f_o(s_f), .cout_o(s_cout)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: {cout, result}
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op, input logic cin);
        logic [W:0] ext_cin;
        ext_cin = {{W{1'b0}}, cin};
        if (op[3] === 1'b1) begin
            if (op[2]) return {a[W-1], a[W-2:0], 1'b0};
            return {a[0], 1'b0, a[W-1:1]};
        end
        if (op[2]) begin
            case (op[1:0])
                2'b00:   return {1'b0, a & b};
                2'b01:   return {1'b0, a | b};
                2'b10:   return {1'b0, a ^ b};
                default: return {1'b0, ~(a | b)};
            endcase
        end
        case (op[1:0])
            2'b00:   return {1'b0, a} + ext_cin;
            2'b01:   return {1'b0, a} + {1'b0, b} + ext_cin;
            2'b10:   return {1'b0, a} + {1'b0, ~b} + ext_cin;
            default: return {1'b0, ~a} + {1'b0, b} + ext_cin;
        endcase
    endfunction

    // Called #1 after a rising edge. Cycle 0 presents start; done is expected in cycle 1 (shift) or W+1.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic cin, input int inject);
        logic [W:0]   exp;
        logic [W-1:0] got_res;
        logic         got_cout;
        int           lat, done_at, done_cnt;
        exp      = model(a, b, op, cin);
        lat      = (op[3] === 1'b1) ? 1 : W + 1;
        done_at  = -1;
        done_cnt = 0;
        got_res  = '0;
        got_cout = 1'b0;
        start = 1'b1; a_in = a; b_in = b; op_in = op; cin_in = cin;
        @(posedge clk); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom; cin_in = 1'(($urandom));
        for (int cyc = 1; cyc <= W + 4; cyc++) begin
            if (cyc == inject) begin
                start = 1'b1;
                op_in = 4'b0001;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at  = cyc;
                    got_res  = result;
                    got_cout = cout;
                end
            end
            if (cyc == 2 && lat > 1) begin
                check({tag, " hold_prev"}, 64'(result), 64'(last_res));
                check({tag, " busy_run"}, 64'(busy), 64'd1);
            end
            if (cyc == 4 && lat > 1) begin
                check({tag, " slice_sel"}, 64'(s_sel), 64'(op));
                check({tag, " slice_ab"}, 64'({s_a, s_b}), 64'({a[3], b[3]}));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, 64'(done_at), 64'(lat));
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " result"}, 64'(got_res), 64'(exp[W-1:0]));
        check({tag, " cout"}, 64'(got_cout), 64'(exp[W]));
        check({tag, " idle_after"}, 64'(busy), 64'd0);
        last_res = exp[W-1:0];
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " result"}, 64'(result), 64'd0);
        check({tag, " cout"}, 64'(cout), 64'd0);
        check({tag, " slices"}, 64'({s_a, s_b, s_cin, s_sel}), 64'd0);
    endtask

    initial begin
        int saw_done;
        #2 rst_ni = 1'b0;
        #1 check_zero_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 1'b0, 0);
        run_op("sub_pos", 32'd5, 32'd3, 4'b0010, 1'b1, 0);
        run_op("sub_neg", 32'd3, 32'd5, 4'b0010, 1'b1, 0);
        run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 1'b1, 0);
        run_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110, 1'b0, 0);
        run_op("shl", 32'h8000_0001, 32'h1234_5678, 4'b1100, 1'b0, 0);
        run_op("shr", 32'h8000_0001, 32'h1234_5678, 4'b1000, 1'b1, 0);
        run_op("shl_xop", 32'h8000_0001, 32'h0, 4'b11xx, 1'bx, 0);
        run_op("start_in_run", 32'h1234_5678, 32'h1111_1111, 4'b0001, 1'b0, 10);

        // start held only during the DONE cycle must not be accepted
        start = 1'b1; a_in = 32'd7; b_in = 32'd0; op_in = 4'b1000;
        @(posedge clk); #1;
        check("done_then_start done", 64'(done), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_then_start idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("done_then_start no_reaccept", 64'({busy, done}), 64'd0);
        last_res = 32'd3;

        // reset in the middle of an add
        start = 1'b1; a_in = 32'hAAAA_5555; b_in = 32'h0F0F_0F0F; op_in = 4'b0001; cin_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_ni = 1'b0;
        #1 check_zero_outputs("mid_reset");
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        check("mid_reset no_done", 64'(saw_done), 64'd0);
        rst_ni = 1'b1;
        last_res = '0;
        run_op("add_after_reset", 32'd2, 32'd2, 4'b0001, 1'b0, 0);

        for (int n = 0; n < 16; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            run_op($sformatf("rand%0d", n), $urandom, $urandom, rop, 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
